// File: rtl/wave_capture.sv
// ---------------------------------------------------------------------------
// wave_capture
//
// Writer side of a 512-entry, dual-buffered wave sample RAM. The display
// reads one half of the RAM, selected by read_index. This block watches the
// codec sample stream for a positive zero crossing, which is a negative
// sample followed by a non-negative one. On a crossing it stores 256
// consecutive samples into the other half. It then waits until the display
// is idle and flips read_index so that the display shows the new capture.
//
// Ports
//   clk                system clock
//   reset              synchronous, active-high reset
//   new_sample_ready   1-cycle strobe, new_sample_in is valid this cycle
//   new_sample_in      signed two's-complement audio sample (IN_W bits)
//   wave_display_idle  high while the display is outside its active region
//   write_address      RAM write address {~read_index, index}
//   write_enable       RAM write strobe, one cycle per stored sample
//   write_sample       unsigned (offset-binary) sample, top OUT_W bits
//   read_index         RAM half the display reads
// ---------------------------------------------------------------------------
module wave_capture #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int HALF_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_sample_ready,
    input  logic [IN_W-1:0]      new_sample_in,
    input  logic                 wave_display_idle,
    output logic [HALF_BITS:0]   write_address,
    output logic                 write_enable,
    output logic [OUT_W-1:0]     write_sample,
    output logic                 read_index
);

    typedef enum logic [1:0] {
        ARMED,      // looking for a negative -> non-negative transition
        ACTIVE,     // storing consecutive samples
        WAIT_IDLE   // capture complete, waiting to flip the display half
    } state_t;

    state_t               state_q;
    logic [HALF_BITS-1:0] index_q;
    logic                 prev_neg_q;
    logic                 read_index_q;
    logic                 write_enable_q;
    logic [HALF_BITS:0]   write_address_q;
    logic [OUT_W-1:0]     write_sample_q;

    logic                 sample_neg;
    logic [OUT_W-1:0]     write_sample_d;
    logic                 unused_low_bits;

    assign sample_neg = new_sample_in[IN_W-1];

    // Inverting the sign bit turns two's complement into offset binary.
    // Zero therefore maps to mid-scale (8'h80 for the default widths).
    assign write_sample_d = {~new_sample_in[IN_W-1], new_sample_in[IN_W-2 -: OUT_W-1]};

    // The low bits below the stored slice are deliberately dropped.
    assign unused_low_bits = ^new_sample_in[IN_W-OUT_W-1:0];

    // NOTE: state registers use non-blocking (<=) assignments so that every
    // read inside this block sees the value from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARMED;
            index_q         <= '0;
            prev_neg_q      <= 1'b0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            write_enable_q <= 1'b0;

            if (new_sample_ready) begin
                prev_neg_q <= sample_neg;
            end

            case (state_q)
                ARMED: begin
                    if (new_sample_ready && prev_neg_q && !sample_neg) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= {~read_index_q, {HALF_BITS{1'b0}}};
                        write_sample_q  <= write_sample_d;
                        index_q         <= HALF_BITS'(1);
                        state_q         <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    if (new_sample_ready) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= {~read_index_q, index_q};
                        write_sample_q  <= write_sample_d;
                        // The last entry ends the capture, so the index never wraps here.
                        if (index_q == {HALF_BITS{1'b1}}) begin
                            index_q <= '0;
                            state_q <= WAIT_IDLE;
                        end else begin
                            index_q <= index_q + HALF_BITS'(1);
                        end
                    end
                end

                WAIT_IDLE: begin
                    if (wave_display_idle) begin
                        read_index_q <= ~read_index_q;
                        // This overrides the sample-driven update above. A new
                        // negative sample is then needed before the next trigger.
                        prev_neg_q   <= 1'b0;
                        state_q      <= ARMED;
                    end
                end

                default: begin
                    state_q    <= ARMED;
                    index_q    <= '0;
                    prev_neg_q <= 1'b0;
                end
            endcase
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// ---------------------------------------------------------------------------
// tb_wave_capture
//
// Directed testbench for wave_capture. The stimulus pushes each expected RAM
// store (address and data) into a queue. A monitor pops one entry for every
// write_enable pulse and compares it. Other checks cover the reset state,
// the read_index flip timing and the number of writes.
// ---------------------------------------------------------------------------
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors     = 0;
    int  miscompares = 0;
    int  writes_seen = 0;
    int  base;

    wave_capture dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    // Monitor: outputs change on posedge, so sample them on negedge.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            writes_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         write_address, write_sample);
            end else begin
                mon_e = exp_q.pop_front();
                if (write_address !== mon_e.addr || write_sample !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL store: got addr %h data %h, required addr %h data %h",
                             write_address, write_sample, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Inputs are driven 1 time unit after posedge. Back-to-back calls keep
    // the strobe high on consecutive cycles.
    task automatic send(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
    endtask

    task automatic send_store(input logic [15:0] s, input logic [8:0] addr, input logic [7:0] data);
        exp_q.push_back('{addr: addr, data: data});
        send(s);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Let the last registered write reach the monitor, then confirm that
    // every expected store has been seen.
    task automatic drain(input string name);
        @(negedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Expected offset-binary byte for a sample value of k<<8 (k in 0..255).
    // Values k >= 128 are negative as 16-bit quantities.
    function automatic logic [7:0] shifted_byte(input int k);
        return (k < 128) ? 8'(8'h80 + k) : 8'(k - 128);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        wait_cycles(2);
        check("reset_we",   write_enable,  0);
        check("reset_addr", write_address, 0);
        check("reset_data", write_sample,  0);
        check("reset_ridx", read_index,    0);
        reset = 1'b0;

        // 1: positive-only samples never trigger.
        base = writes_seen;
        send(16'd5);
        send(16'd7);
        drain("t1_drain");
        check("t1_no_write", writes_seen - base, 0);
        check("t1_ridx", read_index, 0);

        // 2: -3 then +2 triggers. The first store goes to the top half, index 0.
        base = writes_seen;
        send(16'hFFFD);
        send_store(16'h0002, 9'h100, 8'h80);
        drain("t2_drain");

        // 3: 255 more strobes complete the capture, then samples are ignored.
        for (int k = 0; k < 255; k++) begin
            v = 16'(k) << 8;
            send_store(v, 9'(9'h101 + k), shifted_byte(k));
        end
        drain("t3_drain");
        check("t3_count", writes_seen - base, 256);
        base = writes_seen;
        send(16'hFFFF);
        send(16'h0001);
        send(16'hFFFF);
        send(16'h0005);
        drain("t3_wait_drain");
        check("t3_no_write", writes_seen - base, 0);

        // 4: hold idle low, then raise it. The flip happens one cycle later.
        wait_cycles(100);
        check("t4_ridx_hold", read_index, 0);
        wave_display_idle = 1'b1;
        wait_cycles(1);
        check("t4_ridx_flip", read_index, 1);
        wave_display_idle = 1'b0;

        // 5: prev_neg was cleared, so +4 alone does not trigger. Then -1, 0
        //    triggers into the bottom half.
        base = writes_seen;
        send(16'h0004);
        drain("t5_no_trig_drain");
        check("t5_no_trig", writes_seen - base, 0);
        send(16'hFFFF);
        send_store(16'h0000, 9'h000, 8'h80);
        for (int k = 1; k < 256; k++) begin
            v = 16'(k) << 8;
            // Idle is already high when WAIT is entered, so the flip follows
            // the last store by one cycle.
            if (k == 255) wave_display_idle = 1'b1;
            send_store(v, 9'(k), shifted_byte(k));
        end
        check("t5_ridx_before_flip", read_index, 1);
        wait_cycles(1);
        check("t5_ridx_after_flip", read_index, 0);
        wave_display_idle = 1'b0;
        drain("t5_drain");
        check("t5_count", writes_seen - base, 256);

        // 6: reset at index 100. The last stored sample is negative, so
        //    prev_neg would be set if the reset did not clear it.
        base = writes_seen;
        send(16'hFFFF);
        send_store(16'h0001, 9'h100, 8'h80);
        for (int k = 1; k < 99; k++) begin
            v = 16'(k) << 8;
            send_store(v, 9'(9'h100 + k), shifted_byte(k));
        end
        send_store(16'hFF00, 9'h163, 8'h7F);
        reset = 1'b1;
        wait_cycles(1);
        check("t6_we",   write_enable,  0);
        check("t6_ridx", read_index,    0);
        check("t6_addr", write_address, 0);
        check("t6_data", write_sample,  0);
        reset = 1'b0;
        check("t6_count", writes_seen - base, 100);
        base = writes_seen;
        send(16'h0003);
        drain("t6_no_trig_drain");
        check("t6_no_trig", writes_seen - base, 0);
        send(16'hFFFB);
        send_store(16'h0003, 9'h100, 8'h80);
        send_store(16'h7FFF, 9'h101, 8'hFF);
        send_store(16'h8000, 9'h102, 8'h00);
        drain("t6_restart_drain");
        check("t6_restart_count", writes_seen - base, 3);

        wait_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
